lru_set_policy: RTL and testbench

- Multi-set successor to the single-set age-counter LRU eviction policy.
- Holds a true-LRU age permutation plus a valid bit for each of NUM_SETS x NUM_WAYS entries.
- Accepts touch (hit/allocate) and invalidate updates, and returns a registered victim for a requested set.
- Sits between the cache tag pipeline and the fill/eviction controller.

---
 rtl/lru_set_policy.sv | 196 +++++++++++++++++++
 tb/tb_lru_set_policy.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lru_set_policy.sv
// lru_set_policy: true-LRU replacement state for NUM_SETS x NUM_WAYS entries.
// Each set holds an age permutation (0 = MRU, NUM_WAYS-1 = LRU) plus a valid bit
// per way. Touches promote a way to MRU; invalidates demote it to LRU and clear
// its valid bit. A victim query returns a registered result one cycle later.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   touch_valid/alloc/set/way  hit or allocate update (touch_way one-hot)
//   inv_valid/set/way, inv_ready  invalidate request; ready drops when a touch
//                              targets the same set in the same cycle
//   vic_req/vic_set            victim query for a set
//   vic_valid/way/idx/none     registered victim result (vic_valid is a pulse)
//   err_touch                  registered pulse when touch_way was multi-hot
//
// Optional feature, macro LRU_WAY_LOCK_EN: adds lock_valid/lock_set/lock_way/
// lock_val ports and a per-way lock bit that removes a way from victim choice.
module lru_set_policy #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4,
    localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
    localparam int AGE_W = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                reset,
`ifdef LRU_WAY_LOCK_EN
    input  logic                lock_valid,
    input  logic [SET_W-1:0]    lock_set,
    input  logic [AGE_W-1:0]    lock_way,
    input  logic                lock_val,
`endif
    input  logic                touch_valid,
    input  logic                touch_alloc,
    input  logic [SET_W-1:0]    touch_set,
    input  logic [NUM_WAYS-1:0] touch_way,
    input  logic                inv_valid,
    output logic                inv_ready,
    input  logic [SET_W-1:0]    inv_set,
    input  logic [AGE_W-1:0]    inv_way,
    input  logic                vic_req,
    input  logic [SET_W-1:0]    vic_set,
    output logic                vic_valid,
    output logic [NUM_WAYS-1:0] vic_way,
    output logic [AGE_W-1:0]    vic_idx,
    output logic                vic_none,
    output logic                err_touch
);

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_WAYS - 1);

    logic [NUM_SETS-1:0][NUM_WAYS-1:0][AGE_W-1:0] age_q;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]            valid_q;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]            lock_q;

    // ---------------------------------------------------------------
    // Touch decode
    // ---------------------------------------------------------------
    logic             touch_multi;
    logic             touch_fire;
    logic [AGE_W-1:0] touch_idx;
    logic [AGE_W-1:0] touch_age;

    // x & (x-1) clears the lowest set bit; anything left means multi-hot.
    assign touch_multi = (touch_way & (touch_way - NUM_WAYS'(1))) != '0;
    assign touch_fire  = touch_valid && (touch_way != '0) && !touch_multi;

    always_comb begin
        touch_idx = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (touch_way[w]) begin
                touch_idx = AGE_W'(w);
            end
        end
    end

    assign touch_age = age_q[touch_set][touch_idx];

    // ---------------------------------------------------------------
    // Invalidate handshake: a touch to the same set wins the cycle.
    // ---------------------------------------------------------------
    logic             inv_fire;
    logic [AGE_W-1:0] inv_age;

    assign inv_ready = !(touch_valid && (touch_set == inv_set));
    assign inv_fire  = inv_valid && inv_ready;
    assign inv_age   = age_q[inv_set][inv_way];

    // ---------------------------------------------------------------
    // Age / valid state. When touch and invalidate both fire they are
    // guaranteed to target different sets, so their updates never overlap.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_q[s][w]   <= AGE_W'(w);
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else begin
            for (int s = 0; s < NUM_SETS; s++) begin
                if (touch_fire && (touch_set == SET_W'(s))) begin
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        if (touch_way[w]) begin
                            age_q[s][w]   <= '0;
                            valid_q[s][w] <= valid_q[s][w] | touch_alloc;
                        end else if (age_q[s][w] < touch_age) begin
                            age_q[s][w] <= age_q[s][w] + AGE_W'(1);
                        end
                    end
                end
                if (inv_fire && (inv_set == SET_W'(s))) begin
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        if (inv_way == AGE_W'(w)) begin
                            age_q[s][w]   <= AGE_MAX;
                            valid_q[s][w] <= 1'b0;
                        end else if (age_q[s][w] > inv_age) begin
                            age_q[s][w] <= age_q[s][w] - AGE_W'(1);
                        end
                    end
                end
            end
        end
    end

`ifdef LRU_WAY_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= '0;
        end else if (lock_valid) begin
            lock_q[lock_set][lock_way] <= lock_val;
        end
    end
`else
    assign lock_q = '0;
`endif

    // ---------------------------------------------------------------
    // Victim selection on the pre-update state of the queried set.
    // ---------------------------------------------------------------
    logic [NUM_WAYS-1:0][AGE_W-1:0] sel_age;
    logic [NUM_WAYS-1:0]            sel_valid;
    logic [NUM_WAYS-1:0]            sel_lock;
    logic                           found_inv;
    logic                           found_lru;
    logic [AGE_W-1:0]               inv_pick;
    logic [AGE_W-1:0]               lru_pick;
    logic                           nxt_none;
    logic [AGE_W-1:0]               nxt_idx;
    logic [NUM_WAYS-1:0]            nxt_way;

    assign sel_age   = age_q[vic_set];
    assign sel_valid = valid_q[vic_set];
    assign sel_lock  = lock_q[vic_set];

    always_comb begin
        found_inv = 1'b0;
        found_lru = 1'b0;
        inv_pick  = '0;
        lru_pick  = '0;
        // Scan downwards so the lowest-index invalid way is the last to win.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!sel_valid[w] && !sel_lock[w]) begin
                found_inv = 1'b1;
                inv_pick  = AGE_W'(w);
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if ((sel_age[w] == AGE_MAX) && !sel_lock[w]) begin
                found_lru = 1'b1;
                lru_pick  = AGE_W'(w);
            end
        end
        nxt_none = !found_inv && !found_lru;
        nxt_idx  = found_inv ? inv_pick : (found_lru ? lru_pick : '0);
        nxt_way  = nxt_none ? '0 : (NUM_WAYS'(1) << nxt_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vic_valid <= 1'b0;
            vic_way   <= '0;
            vic_idx   <= '0;
            vic_none  <= 1'b0;
            err_touch <= 1'b0;
        end else begin
            vic_valid <= vic_req;
            err_touch <= touch_valid && touch_multi;
            if (vic_req) begin
                vic_way  <= nxt_way;
                vic_idx  <= nxt_idx;
                vic_none <= nxt_none;
            end
        end
    end

endmodule

// File: tb/tb_lru_set_policy.sv
module tb_lru_set_policy;

    localparam int NS = 16;
    localparam int NW = 4;
    localparam int SW = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          touch_valid;
    logic          touch_alloc;
    logic [SW-1:0] touch_set;
    logic [NW-1:0] touch_way;
    logic          inv_valid;
    logic          inv_ready;
    logic [SW-1:0] inv_set;
    logic [AW-1:0] inv_way;
    logic          vic_req;
    logic [SW-1:0] vic_set;
    logic          vic_valid;
    logic [NW-1:0] vic_way;
    logic [AW-1:0] vic_idx;
    logic          vic_none;
    logic          err_touch;
`ifdef LRU_WAY_LOCK_EN
    logic          lock_valid;
    logic [SW-1:0] lock_set;
    logic [AW-1:0] lock_way;
    logic          lock_val;
`endif

    always #5 clk = ~clk;

    lru_set_policy #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef LRU_WAY_LOCK_EN
        .lock_valid  (lock_valid),
        .lock_set    (lock_set),
        .lock_way    (lock_way),
        .lock_val    (lock_val),
`endif
        .touch_valid (touch_valid),
        .touch_alloc (touch_alloc),
        .touch_set   (touch_set),
        .touch_way   (touch_way),
        .inv_valid   (inv_valid),
        .inv_ready   (inv_ready),
        .inv_set     (inv_set),
        .inv_way     (inv_way),
        .vic_req     (vic_req),
        .vic_set     (vic_set),
        .vic_valid   (vic_valid),
        .vic_way     (vic_way),
        .vic_idx     (vic_idx),
        .vic_none    (vic_none),
        .err_touch   (err_touch)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {none, idx[1:0], way[3:0]}
    logic [6:0] sb[$];

    int m_age[NS][NW];
    bit m_valid[NS][NW];
    bit m_lock[NS][NW];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                m_age[s][w]   = w;
                m_valid[s][w] = 1'b0;
                m_lock[s][w]  = 1'b0;
            end
        end
        sb.delete();
    endtask

    task automatic model_vic(input int s, output logic [6:0] r);
        int idx;
        idx = -1;
        for (int w = 0; w < NW; w++)
            if (idx < 0 && !m_valid[s][w] && !m_lock[s][w]) idx = w;
        if (idx < 0)
            for (int w = 0; w < NW; w++)
                if (m_age[s][w] == NW - 1 && !m_lock[s][w]) idx = w;
        if (idx < 0) r = 7'b1_00_0000;
        else         r = {1'b0, AW'(idx), NW'(1 << idx)};
    endtask

    task automatic drive_idle();
        touch_valid = 1'b0; touch_alloc = 1'b0; touch_set = '0; touch_way = '0;
        inv_valid = 1'b0; inv_set = '0; inv_way = '0;
        vic_req = 1'b0; vic_set = '0;
`ifdef LRU_WAY_LOCK_EN
        lock_valid = 1'b0; lock_set = '0; lock_way = '0; lock_val = 1'b0;
`endif
    endtask

    // One clock of stimulus: drive, check combinational ready, update the
    // model from the pre-edge state, clock, then check registered outputs.
    task automatic cycle(input bit tv, input bit ta, input int ts, input logic [3:0] tw,
                         input bit iv, input int is, input int iw,
                         input bit vr, input int vs);
        logic [6:0] e;
        logic [6:0] got;
        bit exp_rdy;
        int tidx, t_age, i_age;
        touch_valid = tv; touch_alloc = ta; touch_set = SW'(ts); touch_way = tw;
        inv_valid = iv; inv_set = SW'(is); inv_way = AW'(iw);
        vic_req = vr; vic_set = SW'(vs);
        #1;
        exp_rdy = !(tv && ts == is);
        chk("inv_ready", inv_ready, exp_rdy);
        if (vr) begin
            model_vic(vs, e);
            sb.push_back(e);
        end
        if (tv && $countones(tw) == 1) begin
            tidx = 0;
            for (int w = 0; w < NW; w++) if (tw[w]) tidx = w;
            t_age = m_age[ts][tidx];
            for (int w = 0; w < NW; w++) begin
                if (w == tidx) m_age[ts][w] = 0;
                else if (m_age[ts][w] < t_age) m_age[ts][w] = m_age[ts][w] + 1;
            end
            if (ta) m_valid[ts][tidx] = 1'b1;
        end
        if (iv && exp_rdy) begin
            i_age = m_age[is][iw];
            for (int w = 0; w < NW; w++) begin
                if (w == iw) begin
                    m_age[is][w]   = NW - 1;
                    m_valid[is][w] = 1'b0;
                end else if (m_age[is][w] > i_age) begin
                    m_age[is][w] = m_age[is][w] - 1;
                end
            end
        end
`ifdef LRU_WAY_LOCK_EN
        if (lock_valid) m_lock[lock_set][lock_way] = lock_val;
`endif
        tick();
        chk("err_touch", err_touch, tv && ($countones(tw) > 1));
        chk("vic_valid", vic_valid, vr);
        if (vic_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_empty: observed vic_valid=1 expected no result");
            end else begin
                got = {vic_none, vic_idx, vic_way};
                e = sb.pop_front();
                chk("victim", got, e);
            end
        end
        drive_idle();
    endtask

    task automatic touch(input int s, input int w, input bit alloc);
        cycle(1'b1, alloc, s, NW'(1 << w), 1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic inv(input int s, input int w);
        cycle(1'b0, 1'b0, 0, 4'b0000, 1'b1, s, w, 1'b0, 0);
    endtask

    task automatic query(input int s);
        cycle(1'b0, 1'b0, 0, 4'b0000, 1'b0, 0, 0, 1'b1, s);
    endtask

    task automatic chk_vic(input string tag, input logic [3:0] way, input logic [1:0] idx, input logic none);
        chk({tag, "_way"}, vic_way, way);
        chk({tag, "_idx"}, vic_idx, idx);
        chk({tag, "_none"}, vic_none, none);
    endtask

`ifdef LRU_WAY_LOCK_EN
    task automatic lock_op(input int s, input int w, input bit v);
        lock_valid = 1'b1; lock_set = SW'(s); lock_way = AW'(w); lock_val = v;
        cycle(1'b0, 1'b0, 0, 4'b0000, 1'b0, 0, 0, 1'b0, 0);
    endtask
`endif

    initial begin
        logic [3:0] tw;
        int r;
        drive_idle();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_vic_valid", vic_valid, 1'b0);
        chk("rst_vic_way", vic_way, 4'b0000);
        chk("rst_vic_idx", vic_idx, 2'd0);
        chk("rst_vic_none", vic_none, 1'b0);
        chk("rst_err_touch", err_touch, 1'b0);

        // Empty set query, then the result pulse must drop
        query(2);
        chk_vic("q_set2", 4'b0001, 2'd0, 1'b0);
        cycle(1'b0, 1'b0, 0, 4'b0000, 1'b0, 0, 0, 1'b0, 0);
        chk("pulse_drop", vic_valid, 1'b0);
        chk_vic("hold", 4'b0001, 2'd0, 1'b0);

        // Fill set 1: ages {3,2,1,0}
        for (int w = 0; w < NW; w++) touch(1, w, 1'b1);
        query(1);
        chk_vic("fill_s1", 4'b0001, 2'd0, 1'b0);

        // Hit way 0: ages {0,3,2,1}
        touch(1, 0, 1'b0);
        query(1);
        chk_vic("hit_s1", 4'b0010, 2'd1, 1'b0);
        query(0);
        chk_vic("s0_untouched", 4'b0001, 2'd0, 1'b0);

        // Invalidate way 3: ages {0,2,1,3}, way 3 invalid
        inv(1, 3);
        query(1);
        chk_vic("inv_s1", 4'b1000, 2'd3, 1'b0);

        // Multi-hot touch: error pulse, no state change
        cycle(1'b1, 1'b1, 1, 4'b0110, 1'b0, 0, 0, 1'b0, 0);
        chk("err_pulse", err_touch, 1'b1);
        cycle(1'b0, 1'b0, 0, 4'b0000, 1'b0, 0, 0, 1'b0, 0);
        chk("err_clear", err_touch, 1'b0);
        query(1);
        chk_vic("multi_noop", 4'b1000, 2'd3, 1'b0);
        touch(1, 3, 1'b1);              // ages {1,3,2,0}
        query(1);
        chk_vic("realloc3", 4'b0010, 2'd1, 1'b0);

        // Zero touch_way: ignored, no error
        cycle(1'b1, 1'b1, 1, 4'b0000, 1'b0, 0, 0, 1'b0, 0);

        // Same-set collision: touch wins, invalidate waits a cycle
        cycle(1'b1, 1'b0, 1, 4'b0001, 1'b1, 1, 2, 1'b0, 0);   // ages {0,3,2,1}
        cycle(1'b0, 1'b0, 0, 4'b0000, 1'b1, 1, 2, 1'b0, 0);   // ages {0,2,3,1}
        query(1);
        chk_vic("held_inv", 4'b0100, 2'd2, 1'b0);
        touch(1, 2, 1'b1);              // ages {1,3,0,2}
        query(1);
        chk_vic("after_held", 4'b0010, 2'd1, 1'b0);

        // Different sets same cycle: both apply
        cycle(1'b1, 1'b1, 4, 4'b0010, 1'b1, 1, 1, 1'b0, 0);
        query(1);
        chk_vic("dual_s1", 4'b0010, 2'd1, 1'b0);
        query(4);
        chk_vic("dual_s4", 4'b0001, 2'd0, 1'b0);

        // Back-to-back queries
        cycle(1'b0, 1'b0, 0, 4'b0000, 1'b0, 0, 0, 1'b1, 1);
        cycle(1'b0, 1'b0, 0, 4'b0000, 1'b0, 0, 0, 1'b1, 4);

`ifdef LRU_WAY_LOCK_EN
        // Set 3 allocated 2,0,1,3 -> ages {2,1,3,0}, LRU is way 2
        touch(3, 2, 1'b1);
        touch(3, 0, 1'b1);
        touch(3, 1, 1'b1);
        touch(3, 3, 1'b1);
        for (int w = 0; w < NW; w++) lock_op(3, w, 1'b1);
        query(3);
        chk_vic("all_locked", 4'b0000, 2'd0, 1'b1);
        lock_op(3, 2, 1'b0);
        query(3);
        chk_vic("unlock2", 4'b0100, 2'd2, 1'b0);
`endif

        // Reset during a query discards the pending result
        vic_req = 1'b1;
        vic_set = SW'(1);
        reset = 1'b1;
        tick();
        chk("rst_mid_valid", vic_valid, 1'b0);
        chk("rst_mid_way", vic_way, 4'b0000);
        reset = 1'b0;
        drive_idle();
        model_reset();
        query(1);
        chk_vic("post_rst", 4'b0001, 2'd0, 1'b0);

        // Random traffic over a few sets against the model
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      tw = NW'(1 << $urandom_range(0, 3));
            else if (r < 8) tw = 4'b0000;
            else            tw = 4'($urandom_range(0, 15));
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), tw,
                  ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $error("FAIL sb_leftover: observed %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
